tt_um_fifo_reader: RTL and testbench
====================================

# tt_um_fifo_reader

Byte-wide synchronous FIFO tile whose focus is the read end: bytes pushed from the dedicated inputs are drained through a pop handshake onto the dedicated outputs, with status flags on the bidirectional pins. It sits as a Tiny Tapeout user module and is the consumer-side counterpart of our existing input-latching tile. It adds storage, pointer arithmetic, full/empty tracking and sticky error reporting.

## Interface
- DEPTH, 8: number of byte entries; power of two, 2..16.
- WIDTH, 8: data width; fixed by the pin map.
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  design enable; low freezes all state.
- ui_in  input  8  write data.
- uio_in  input  8  [0] wr_en, [1] rd_en; [7:2] ignored.
- uo_out  output  8  registered read data (last popped byte).
- uio_out  output  8  [2] full, [3] empty, [4] overflow (sticky), [5] underflow (sticky), [6] out_valid; [1:0], [7] driven 0.
- uio_oe  output  8  constant 8'b0111_1100.

## Operation
- Storage: DEPTH x 8 array; wr_ptr, rd_ptr of clog2(DEPTH) bits, wrap modulo DEPTH; count of clog2(DEPTH)+1 bits, 0..DEPTH.
- Gated strobes: wr = ena & uio_in[0]; rd = ena & uio_in[1].
- push = wr & (!full | rd). pop = rd & !empty.
- On push: mem[wr_ptr] <= ui_in, wr_ptr++.
- On pop: uo_out <= mem[rd_ptr], rd_ptr++.
- count += push - pop; full = (count == DEPTH); empty = (count == 0); both registered, derived from next count.
- wr while full and no rd: byte dropped, overflow set.
- rd while empty: no pop, uo_out unchanged, underflow set (even if wr same cycle).
- Simultaneous wr & rd when full: both occur, count stays DEPTH, full stays 1.
- Simultaneous wr & rd when empty: push only, count becomes 1.
- out_valid = 1 for exactly the cycle after a pop, else 0.
- overflow/underflow cleared only by reset.
- ena low: no push/pop, flags and uo_out hold, out_valid 0.

## Timing
- Reset (async assert, sync release): uo_out 0, pointers 0, count 0, empty 1, full 0, overflow 0, underflow 0, out_valid 0.
- Pop latency 1: rd sampled at edge N -> uo_out/out_valid updated after edge N.
- Write-to-read: byte pushed at edge N; empty falls after edge N; earliest pop at edge N+1; data on uo_out after N+1.
- Flags update after the same edge that changes count; no combinational path from uio_in to uio_out or uo_out.
- Reset mid-operation discards all contents; memory array need not be cleared (count=0 masks it).

## Structure
- Package fifo_pkg: pin-index constants (WR_EN_BIT=0, RD_EN_BIT=1, FULL_BIT=2, EMPTY_BIT=3, OVF_BIT=4, UNF_BIT=5, VALID_BIT=6), UIO_OE_MASK=8'b0111_1100, DEPTH default.
- Sub-module fifo_mem: DEPTH x WIDTH register file, synchronous write port, asynchronous read port, no reset.
- Top holds pointers, count, flags, output register.

## Test plan
- Reset: hold rst_n=0 mid-clock -> uo_out=0x00, uio_out=0x08 immediately; uio_oe=0x7C always.
- Ordered drain: push 0x11,0x22,0x33, then 3 pops -> uo_out 0x11,0x22,0x33 on successive cycles, out_valid high each, empty=1 after third.
- Fill/overflow: push 0x00..0x07 (full=1), push 0xAA -> overflow=1, count stays 8; drain 8 -> 0x00..0x07, 0xAA never appears.
- Full simultaneous: full with 0x00..0x07, wr=0xF0 & rd same cycle -> uo_out=0x00, full stays 1; drain yields 0x01..0x07,0xF0.
- Empty simultaneous/underflow: empty, wr=0x5A & rd -> underflow=1, uo_out unchanged, empty=0; next pop -> 0x5A.
- ena gating and wrap: ena=0 with wr/rd asserted -> no state change; then 20 push/pop pairs of incrementing bytes -> output order preserved across pointer wrap.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the tt_um_fifo_reader tile.
//   - Pin indices into uio_in (strobes) and uio_out (status flags).
//   - Output-enable mask for the bidirectional pins.
//   - Default FIFO depth and fixed data width.
//   - pack_status(): assembles the uio_out status byte from the flag registers.
package fifo_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int DATA_WIDTH    = 8;

  // uio_in strobe positions
  localparam int WR_EN_BIT = 0;
  localparam int RD_EN_BIT = 1;

  // uio_out status positions
  localparam int FULL_BIT  = 2;
  localparam int EMPTY_BIT = 3;
  localparam int OVF_BIT   = 4;
  localparam int UNF_BIT   = 5;
  localparam int VALID_BIT = 6;

  // Only the status pins are driven outward.
  localparam logic [7:0] UIO_OE_MASK = 8'b0111_1100;

  // Unused status positions ([1:0], [7]) stay 0.
  function automatic logic [7:0] pack_status(
    input logic full,
    input logic empty,
    input logic ovf,
    input logic unf,
    input logic valid
  );
    logic [7:0] s;
    s            = 8'h00;
    s[FULL_BIT]  = full;
    s[EMPTY_BIT] = empty;
    s[OVF_BIT]   = ovf;
    s[UNF_BIT]   = unf;
    s[VALID_BIT] = valid;
    return s;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register file backing the FIFO.
//   clk    in   write clock
//   we     in   write enable (one entry written per rising edge)
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
// No reset: stale contents are masked by the FIFO's occupancy count.
module fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Asynchronous read so a pop can register the head byte in the same edge.
  // On a full-FIFO push+pop, waddr == raddr: the read sees the old byte
  // because the write only lands at the edge.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/tt_um_fifo_reader.sv
// tt_um_fifo_reader: byte FIFO tile drained through a pop handshake.
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   design enable; low freezes all state
//   ui_in    in   write data byte
//   uio_in   in   [0] wr_en, [1] rd_en, [7:2] ignored
//   uo_out   out  last popped byte (registered)
//   uio_out  out  [2] full, [3] empty, [4] overflow, [5] underflow,
//                 [6] out_valid; other bits 0
//   uio_oe   out  constant output-enable mask 8'b0111_1100
// All outputs come straight from registers; no combinational path from inputs.
module tt_um_fifo_reader
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  full_reg;
  logic                  empty_reg;
  logic                  ovf_reg;
  logic                  unf_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] uo_out_reg;
  logic [DATA_WIDTH-1:0] rd_data;

  logic wr;
  logic rd;
  logic push;
  logic pop;
  logic ovf_set;
  logic unf_set;

  // Upper strobe pins carry no function.
  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:2]};

  assign wr = ena & uio_in[WR_EN_BIT];
  assign rd = ena & uio_in[RD_EN_BIT];

  // A full FIFO still accepts a write when a pop frees the head slot in the
  // same cycle. An empty FIFO never pops, even if a write arrives alongside.
  assign push    = wr & (~full_reg | rd);
  assign pop     = rd & ~empty_reg;
  assign ovf_set = wr & full_reg & ~rd;
  assign unf_set = rd & empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (ui_in),
    .raddr (rd_ptr_reg),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      uo_out_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        uo_out_reg <= rd_data;
      end
      count_reg <= count_next;
      // Flags follow the new count so they change on the same edge.
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end
      if (unf_set) begin
        unf_reg <= 1'b1;
      end
      // pop is already gated by ena, so this drops to 0 while disabled.
      out_valid_reg <= pop;
    end
  end

  assign uo_out  = uo_out_reg;
  assign uio_out = pack_status(full_reg, empty_reg, ovf_reg, unf_reg, out_valid_reg);
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_fifo_reader.sv
// Testbench for tt_um_fifo_reader: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the FIFO.
module tb_tt_um_fifo_reader;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_fifo_reader #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Reference model
  logic [7:0] m_q[$];
  logic [7:0] m_out;
  bit         m_ovf;
  bit         m_unf;
  bit         m_valid;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s    = 8'h00;
    s[2] = (m_q.size() == DEPTH);
    s[3] = (m_q.size() == 0);
    s[4] = m_ovf;
    s[5] = m_unf;
    s[6] = m_valid;
    return s;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_out   = 8'h00;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
  endtask

  // Advance the model by one clock with the given strobes.
  task automatic model_step(input bit w, input bit r, input logic [7:0] d, input bit e);
    bit was_full;
    bit was_empty;
    m_valid = 1'b0;
    if (!e) return;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (r) begin
      if (!was_empty) begin
        m_out   = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_unf = 1'b1;
      end
    end
    if (w) begin
      if (!was_full || r) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  // One transaction: drive at negedge, sample 1 ns after the rising edge.
  task automatic cycle(input string tag, input bit w, input bit r, input logic [7:0] d, input bit e);
    @(negedge clk);
    ena    = e;
    ui_in  = d;
    uio_in = {6'b0, r, w};
    @(posedge clk);
    #1;
    model_step(w, r, d, e);
    $display("[%0t] %s ena=%0b wr=%0b rd=%0b din=%02h -> uo_out=%02h uio_out=%02h (model %02h %02h)",
             $time, tag, e, w, r, d, uo_out, uio_out, m_out, exp_status());
    check_eq({tag, ".uo_out"}, uo_out, m_out);
    check_eq({tag, ".uio_out"}, uio_out, exp_status());
    check_eq({tag, ".uio_oe"}, uio_oe, 8'h7C);
  endtask

  // Asynchronous reset asserted mid-clock; outputs must clear without an edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    model_reset();
    #1;
    $display("[%0t] %s reset asserted -> uo_out=%02h uio_out=%02h", $time, tag, uo_out, uio_out);
    check_eq({tag, ".rst_uo_out"}, uo_out, 8'h00);
    check_eq({tag, ".rst_uio_out"}, uio_out, 8'h08);
    check_eq({tag, ".rst_uio_oe"}, uio_oe, 8'h7C);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    #3;
    do_reset("init");

    // Ordered drain
    cycle("drain_push", 1, 0, 8'h11, 1);
    cycle("drain_push", 1, 0, 8'h22, 1);
    cycle("drain_push", 1, 0, 8'h33, 1);
    for (int i = 0; i < 3; i++) cycle("drain_pop", 0, 1, 8'h00, 1);
    cycle("drain_idle", 0, 0, 8'h00, 1);

    // Fill and overflow, then drain
    for (int i = 0; i < 8; i++) cycle("fill_push", 1, 0, 8'(i), 1);
    cycle("ovf_push", 1, 0, 8'hAA, 1);
    for (int i = 0; i < 8; i++) cycle("ovf_drain", 0, 1, 8'h00, 1);

    // Full with simultaneous read/write
    do_reset("full_sim");
    for (int i = 0; i < 8; i++) cycle("fs_fill", 1, 0, 8'(i), 1);
    cycle("fs_both", 1, 1, 8'hF0, 1);
    for (int i = 0; i < 8; i++) cycle("fs_drain", 0, 1, 8'h00, 1);

    // Empty with simultaneous read/write: underflow, push only
    do_reset("empty_sim");
    cycle("es_both", 1, 1, 8'h5A, 1);
    cycle("es_pop", 0, 1, 8'h00, 1);
    cycle("es_unf", 0, 1, 8'h00, 1);

    // ena gating, then long push/pop run across pointer wrap
    do_reset("ena_wrap");
    cycle("ena_seed", 1, 0, 8'h77, 1);
    cycle("ena_off", 1, 1, 8'h99, 0);
    cycle("ena_off", 1, 0, 8'h98, 0);
    cycle("ena_off", 0, 1, 8'h00, 0);
    cycle("ena_pop", 0, 1, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      cycle("wrap_push", 1, 0, 8'(8'h40 + i), 1);
      cycle("wrap_pop", 0, 1, 8'h00, 1);
    end

    // Randomized traffic, biased toward the full/empty boundaries
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      bit w, r, e;
      int bias;
      bias = (i / 50) % 2;
      w = ($urandom_range(99) < (bias ? 70 : 35));
      r = ($urandom_range(99) < (bias ? 35 : 70));
      e = ($urandom_range(99) < 90);
      cycle("rand", w, r, 8'($urandom), e);
    end

    // Reset in the middle of traffic discards contents
    for (int i = 0; i < 4; i++) cycle("pre_rst", 1, 0, 8'(8'hC0 + i), 1);
    do_reset("mid_rst");
    cycle("post_rst_pop", 0, 1, 8'h00, 1);
    cycle("post_rst_push", 1, 0, 8'hE1, 1);
    cycle("post_rst_pop", 0, 1, 8'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
